// File: rtl/otg_hpi_pkg.sv
// rtl/otg_hpi_pkg.sv - shared types, HPI register codes and timing helpers for otg_hpi_master
package otg_hpi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WDATA,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_RECOV
  } hpi_state_t;

  localparam logic [1:0] HPI_DATA    = 2'd0;
  localparam logic [1:0] HPI_MAILBOX = 2'd1;
  localparam logic [1:0] HPI_ADDR    = 2'd2;
  localparam logic [1:0] HPI_STATUS  = 2'd3;

  // Every phase must last at least one clock.
  function automatic bit timing_ok(input int cyc);
    return cyc >= 1;
  endfunction

  // The phase timer reloads with CYC-1, so it only needs to hold max(CYC)-1.
  function automatic int timer_width(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/otg_hpi_master_if.sv
// rtl/otg_hpi_master_if.sv - request/response and HPI pin bundle for otg_hpi_master
interface otg_hpi_master_if #(
  parameter int DATA_W = 16,
  parameter int LEN_W  = 8
) ();
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_addr;
  logic [LEN_W-1:0]  req_len;
  logic              wdata_valid;
  logic              wdata_ready;
  logic [DATA_W-1:0] wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_last;
  logic              busy;
  logic [1:0]        otg_hpi_address;
  logic              otg_hpi_cs_n;
  logic              otg_hpi_r_n;
  logic              otg_hpi_w_n;
  logic [DATA_W-1:0] otg_hpi_data_out;
  logic              otg_hpi_data_oe;
  logic [DATA_W-1:0] otg_hpi_data_in;

  // Engine side: takes requests and write data, drives responses and pins.
  modport master (
    input  req_valid, req_write, req_addr, req_len, wdata_valid, wdata, otg_hpi_data_in,
    output req_ready, wdata_ready, rsp_valid, rsp_rdata, rsp_last, busy,
           otg_hpi_address, otg_hpi_cs_n, otg_hpi_r_n, otg_hpi_w_n,
           otg_hpi_data_out, otg_hpi_data_oe
  );

  // Requester/pad side.
  modport slave (
    output req_valid, req_write, req_addr, req_len, wdata_valid, wdata, otg_hpi_data_in,
    input  req_ready, wdata_ready, rsp_valid, rsp_rdata, rsp_last, busy,
           otg_hpi_address, otg_hpi_cs_n, otg_hpi_r_n, otg_hpi_w_n,
           otg_hpi_data_out, otg_hpi_data_oe
  );
endinterface

// File: rtl/hpi_phase_timer.sv
// rtl/hpi_phase_timer.sv - loadable down-counter shared by all HPI bus phases
module hpi_phase_timer #(
  parameter int CNT_W = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);
  logic [CNT_W-1:0] cnt;

  // Reload on phase entry, otherwise count down and rest at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign done = (cnt == '0);
endmodule

// File: rtl/otg_hpi_master.sv
// rtl/otg_hpi_master.sv - HPI strobe engine with programmable timing; bursts enabled by OTG_HPI_BURST_EN
module otg_hpi_master
  import otg_hpi_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int LEN_W      = 8,
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 2,
  parameter int HOLD_CYC   = 1,
  parameter int RECOV_CYC  = 2
) (
  input logic               clk_clk,
  input logic               reset_reset_n,
  otg_hpi_master_if.master  bus
);
  localparam int CNT_W = timer_width(SETUP_CYC, STROBE_CYC, HOLD_CYC, RECOV_CYC);
  localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] RECOV_LD  = CNT_W'(RECOV_CYC - 1);

  if (!(timing_ok(SETUP_CYC) && timing_ok(STROBE_CYC) &&
        timing_ok(HOLD_CYC) && timing_ok(RECOV_CYC))) begin : g_bad_timing
    $error("otg_hpi_master: every phase length must be at least 1");
  end

  hpi_state_t       state;
  logic             wr_q;
  logic             last_beat;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_done;

  hpi_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk_clk),
    .rst_n    (reset_reset_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  // Arm the timer with the next phase length whenever the current phase ends.
  always_comb begin
    tmr_load = 1'b1;
    tmr_val  = SETUP_LD;
    case (state)
      ST_SETUP:  begin tmr_load = tmr_done; tmr_val = STROBE_LD; end
      ST_STROBE: begin tmr_load = tmr_done; tmr_val = HOLD_LD;   end
      ST_HOLD:   begin tmr_load = tmr_done; tmr_val = RECOV_LD;  end
      ST_RECOV:  begin tmr_load = tmr_done; tmr_val = SETUP_LD;  end
      default:   begin tmr_load = 1'b1;     tmr_val = SETUP_LD;  end
    endcase
  end

`ifdef OTG_HPI_BURST_EN
  logic [LEN_W-1:0] beats;

  // Beats still owed in this burst, including the one in flight; a zero length means one beat.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      beats <= '0;
    end else if (state == ST_IDLE && bus.req_valid) begin
      beats <= (bus.req_len == '0) ? LEN_W'(1) : bus.req_len;
    end else if (state == ST_RECOV && tmr_done && !last_beat) begin
      beats <= beats - LEN_W'(1);
    end
  end

  assign last_beat = (beats == LEN_W'(1));
`else
  logic unused_req_len;
  assign unused_req_len = ^bus.req_len;
  assign last_beat      = 1'b1;
`endif

  // Sequencer: every bus-facing output is a register written only here.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state                <= ST_IDLE;
      wr_q                 <= 1'b0;
      bus.req_ready        <= 1'b1;
      bus.wdata_ready      <= 1'b0;
      bus.busy             <= 1'b0;
      bus.rsp_valid        <= 1'b0;
      bus.rsp_last         <= 1'b0;
      bus.rsp_rdata        <= '0;
      bus.otg_hpi_address  <= '0;
      bus.otg_hpi_cs_n     <= 1'b1;
      bus.otg_hpi_r_n      <= 1'b1;
      bus.otg_hpi_w_n      <= 1'b1;
      bus.otg_hpi_data_out <= '0;
      bus.otg_hpi_data_oe  <= 1'b0;
    end else begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_last  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            wr_q                <= bus.req_write;
            bus.otg_hpi_address <= bus.req_addr;
            bus.req_ready       <= 1'b0;
            bus.busy            <= 1'b1;
            if (bus.req_write) begin
              state           <= ST_WDATA;
              bus.wdata_ready <= 1'b1;
            end else begin
              state            <= ST_SETUP;
              bus.otg_hpi_cs_n <= 1'b0;
            end
          end
        end
        ST_WDATA: begin
          if (bus.wdata_valid) begin
            bus.otg_hpi_data_out <= bus.wdata;
            bus.wdata_ready      <= 1'b0;
            bus.otg_hpi_data_oe  <= 1'b1;
            bus.otg_hpi_cs_n     <= 1'b0;
            state                <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (tmr_done) begin
            state           <= ST_STROBE;
            bus.otg_hpi_r_n <= wr_q;
            bus.otg_hpi_w_n <= !wr_q;
          end
        end
        ST_STROBE: begin
          if (tmr_done) begin
            state           <= ST_HOLD;
            bus.otg_hpi_r_n <= 1'b1;
            bus.otg_hpi_w_n <= 1'b1;
            bus.rsp_valid   <= 1'b1;
            bus.rsp_last    <= last_beat;
            bus.rsp_rdata   <= wr_q ? '0 : bus.otg_hpi_data_in;
          end
        end
        ST_HOLD: begin
          if (tmr_done) begin
            state               <= ST_RECOV;
            bus.otg_hpi_cs_n    <= 1'b1;
            bus.otg_hpi_data_oe <= 1'b0;
          end
        end
        ST_RECOV: begin
          if (tmr_done) begin
            if (last_beat) begin
              state         <= ST_IDLE;
              bus.req_ready <= 1'b1;
              bus.busy      <= 1'b0;
            end else if (wr_q) begin
              state           <= ST_WDATA;
              bus.wdata_ready <= 1'b1;
            end else begin
              state            <= ST_SETUP;
              bus.otg_hpi_cs_n <= 1'b0;
            end
          end
        end
        default: begin
          state         <= ST_IDLE;
          bus.req_ready <= 1'b1;
          bus.busy      <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_otg_hpi_master.sv
// tb/tb_otg_hpi_master.sv - directed scoreboard bench for otg_hpi_master
module tb_otg_hpi_master;
  import otg_hpi_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  otg_hpi_master_if #(.DATA_W(16), .LEN_W(8)) bus ();

  otg_hpi_master #(
    .DATA_W(16), .LEN_W(8), .SETUP_CYC(1), .STROBE_CYC(2), .HOLD_CYC(1), .RECOV_CYC(2)
  ) dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .bus           (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int rsp_seen = 0;
  logic [15:0] pad_base = 16'h0;
  logic [16:0] exp_q[$];
  logic [16:0] mon_e;

  // Pad model: read data steps by one after every completed beat.
  assign bus.otg_hpi_data_in = pad_base + 16'(rsp_seen);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int beats_for(input int len);
`ifdef OTG_HPI_BURST_EN
    return (len == 0) ? 1 : len;
`else
    return 1;
`endif
  endfunction

  task automatic set_pad(input logic [15:0] v);
    pad_base = v - 16'(rsp_seen);
  endtask

  // Scoreboard: every response pulse must match the oldest pushed expectation.
  always @(negedge clk) begin
    if (rst_n && bus.rsp_valid) begin
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rsp_rdata", 32'(bus.rsp_rdata), 32'(mon_e[15:0]));
        chk("rsp_last", 32'(bus.rsp_last), 32'(mon_e[16]));
      end
      rsp_seen++;
    end
  end

  task automatic run_read(input string tag, input logic [1:0] addr, input logic [7:0] len,
                          input logic [15:0] p0);
    int nb;
    nb = beats_for(int'(len));
    set_pad(p0);
    for (int i = 0; i < nb; i++) exp_q.push_back({(i == nb - 1), p0 + 16'(i)});
    @(negedge clk);
    chk({tag, "_ready_pre"}, 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = addr; bus.req_len = len;
    @(posedge clk);
    for (int k = 0; k <= 6 * nb; k++) begin
      @(negedge clk);
      if (k == 0) bus.req_valid = 1'b0;
      chk({tag, "_cs_n"}, 32'(bus.otg_hpi_cs_n), (k < 6 * nb && k % 6 < 4) ? 32'd0 : 32'd1);
      chk({tag, "_r_n"}, 32'(bus.otg_hpi_r_n),
          (k < 6 * nb && (k % 6 == 1 || k % 6 == 2)) ? 32'd0 : 32'd1);
      chk({tag, "_w_n"}, 32'(bus.otg_hpi_w_n), 32'd1);
      chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), (k < 6 * nb && k % 6 == 3) ? 32'd1 : 32'd0);
      chk({tag, "_ready"}, 32'(bus.req_ready), (k == 6 * nb) ? 32'd1 : 32'd0);
      if (k < 6 * nb) chk({tag, "_addr"}, 32'(bus.otg_hpi_address), 32'(addr));
    end
    chk({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = 2'd0; bus.req_len = 8'd0;
    bus.wdata_valid = 1'b0; bus.wdata = 16'h0;

    // Reset values.
    @(negedge clk);
    chk("rst_cs_n", 32'(bus.otg_hpi_cs_n), 32'd1);
    chk("rst_r_n", 32'(bus.otg_hpi_r_n), 32'd1);
    chk("rst_w_n", 32'(bus.otg_hpi_w_n), 32'd1);
    chk("rst_oe", 32'(bus.otg_hpi_data_oe), 32'd0);
    chk("rst_addr", 32'(bus.otg_hpi_address), 32'd0);
    chk("rst_dout", 32'(bus.otg_hpi_data_out), 32'd0);
    chk("rst_rsp", 32'(bus.rsp_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_wready", 32'(bus.wdata_ready), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single read of STATUS.
    run_read("rd1", HPI_STATUS, 8'd1, 16'hA55A);

    // Single write of ADDRESS with write data two cycles late.
    exp_q.push_back({1'b1, 16'h0000});
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = HPI_ADDR; bus.req_len = 8'd1;
    bus.wdata = 16'h1234;
    @(posedge clk);
    for (int k = 0; k <= 9; k++) begin
      @(negedge clk);
      if (k == 0) bus.req_valid = 1'b0;
      chk("wr_cs_n", 32'(bus.otg_hpi_cs_n), (k >= 3 && k <= 6) ? 32'd0 : 32'd1);
      chk("wr_oe", 32'(bus.otg_hpi_data_oe), (k >= 3 && k <= 6) ? 32'd1 : 32'd0);
      chk("wr_w_n", 32'(bus.otg_hpi_w_n), (k == 4 || k == 5) ? 32'd0 : 32'd1);
      chk("wr_r_n", 32'(bus.otg_hpi_r_n), 32'd1);
      chk("wr_wready", 32'(bus.wdata_ready), (k < 3) ? 32'd1 : 32'd0);
      chk("wr_rsp_valid", 32'(bus.rsp_valid), (k == 6) ? 32'd1 : 32'd0);
      chk("wr_ready", 32'(bus.req_ready), (k == 9) ? 32'd1 : 32'd0);
      if (k >= 3 && k <= 6) chk("wr_dout", 32'(bus.otg_hpi_data_out), 32'h1234);
      if (k < 9) chk("wr_addr", 32'(bus.otg_hpi_address), 32'(HPI_ADDR));
      if (k == 2) bus.wdata_valid = 1'b1;
      if (k == 3) bus.wdata_valid = 1'b0;
    end
    chk("wr_drained", 32'(exp_q.size()), 32'd0);

    // Write data offered while idle must be ignored.
    bus.wdata = 16'hDEAD; bus.wdata_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("idle_wdata_dout", 32'(bus.otg_hpi_data_out), 32'h1234);
      chk("idle_wdata_cs_n", 32'(bus.otg_hpi_cs_n), 32'd1);
      chk("idle_wdata_wready", 32'(bus.wdata_ready), 32'd0);
    end
    bus.wdata_valid = 1'b0;

    // Bursts and length corner cases.
    run_read("burst4", HPI_DATA, 8'd4, 16'h0001);
    run_read("len0", HPI_MAILBOX, 8'd0, 16'h0BB0);
    run_read("len5", HPI_DATA, 8'd5, 16'h0050);

    // Reset in the middle of a write strobe.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = HPI_MAILBOX; bus.req_len = 8'd1;
    bus.wdata = 16'hBEEF; bus.wdata_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    bus.wdata_valid = 1'b0;
    @(negedge clk);
    chk("rststb_w_n_low", 32'(bus.otg_hpi_w_n), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("rststb_w_n", 32'(bus.otg_hpi_w_n), 32'd1);
    chk("rststb_cs_n", 32'(bus.otg_hpi_cs_n), 32'd1);
    chk("rststb_oe", 32'(bus.otg_hpi_data_oe), 32'd0);
    chk("rststb_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("post_rst_ready", 32'(bus.req_ready), 32'd1);
      chk("post_rst_busy", 32'(bus.busy), 32'd0);
      chk("post_rst_rsp", 32'(bus.rsp_valid), 32'd0);
      chk("post_rst_cs_n", 32'(bus.otg_hpi_cs_n), 32'd1);
    end

    // Back-to-back requests with req_valid held through busy.
    set_pad(16'h0100);
    exp_q.push_back({1'b1, 16'h0100});
    exp_q.push_back({1'b1, 16'h0101});
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = HPI_STATUS; bus.req_len = 8'd1;
    @(posedge clk);
    for (int k = 0; k <= 13; k++) begin
      @(negedge clk);
      chk("b2b_ready", 32'(bus.req_ready), (k == 6 || k == 13) ? 32'd1 : 32'd0);
      chk("b2b_cs_n", 32'(bus.otg_hpi_cs_n), (k <= 3 || (k >= 7 && k <= 10)) ? 32'd0 : 32'd1);
      chk("b2b_rsp_valid", 32'(bus.rsp_valid), (k == 3 || k == 10) ? 32'd1 : 32'd0);
      if (k <= 6) chk("b2b_addr1", 32'(bus.otg_hpi_address), 32'(HPI_STATUS));
      else if (k <= 12) chk("b2b_addr2", 32'(bus.otg_hpi_address), 32'(HPI_MAILBOX));
      if (k == 2) bus.req_addr = HPI_MAILBOX;
      if (k == 7) bus.req_valid = 1'b0;
    end
    chk("b2b_drained", 32'(exp_q.size()), 32'd0);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
